// File: rtl/sigmoid_arbiter.sv
// Four-way round-robin arbiter in front of a shared sigmoid LUT.
// A requester is granted only when a result FIFO slot is reserved for it.
// A tag pipeline that matches the LUT latency records which requester each
// lookup belongs to. When the lookup completes, its result and id are pushed
// into the result FIFO, so results leave in grant order.
module sigmoid_arbiter #(
  parameter int LUT_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [87:0] req_data,
  output logic [3:0]  req_ready,
  output logic        lut_en,
  output logic [8:0]  lut_addr,
  output logic        lut_sign,
  output logic        lut_ovr,
  input  logic [7:0]  lut_dout,
  output logic        act_valid,
  output logic [7:0]  act_data,
  output logic [1:0]  act_id,
  input  logic        act_ready,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // inflight never exceeds LUT_LAT (at most 4)
  localparam int INF_W = 3;
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
  localparam int TID_W = 2 * LUT_LAT;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]       last_grant_reg;
  logic [LUT_LAT-1:0] tag_valid_reg;
  logic [LUT_LAT-1:0] tag_valid_next;
  logic [TID_W-1:0] tag_id_reg;
  logic [TID_W-1:0] tag_id_next;
  logic [INF_W-1:0] inflight_reg;
  logic [INF_W-1:0] inflight_next;
  logic [CNT_W-1:0] fifo_count_reg;
  logic [CNT_W-1:0] fifo_count_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;

  logic [7:0] fifo_data_mem [FIFO_DEPTH];
  logic [1:0] fifo_id_mem   [FIFO_DEPTH];

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic [21:0] req_word [4];
  logic [21:0] sel_word;
  logic [1:0]  cand;
  logic [1:0]  grant_id;
  logic        grant_found;
  logic [3:0]  grant_oh;
  logic        credit_ok;
  logic        retire_valid;
  logic [1:0]  retire_id;
  logic        push;
  logic        pop;

  // Split the packed request bus into one 22-bit word per requester.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign req_word[gi] = req_data[22*gi +: 22];
    end
  endgenerate

  // The credit gate uses only registered counts. A pop in this cycle frees
  // its slot starting in the next cycle.
  assign credit_ok = (SUM_W'(inflight_reg) + SUM_W'(fifo_count_reg)) < SUM_W'(FIFO_DEPTH);

  // Round-robin search that starts one past the last granted requester.
  always_comb begin
    cand        = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    grant_oh    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_reg + 2'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    if (rst || !credit_ok) begin
      grant_found = 1'b0;
    end
    if (grant_found) begin
      grant_oh[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant_oh;
  assign lut_en    = |grant_oh;

  // Map the granted accumulator onto the LUT fields. The outputs stay at
  // zero when nothing issues.
  always_comb begin
    sel_word = req_word[grant_id];
    lut_sign = 1'b0;
    lut_addr = '0;
    lut_ovr  = 1'b0;
    if (lut_en) begin
      lut_sign = sel_word[21];
      lut_addr = sel_word[13:5];
      if (sel_word[21]) begin
        // Negative: saturate unless the integer part is all ones and the
        // fraction is non-zero.
        lut_ovr = (~&sel_word[20:14]) | (~|sel_word[13:5]);
      end else begin
        // Positive: saturate if any integer bit is set.
        lut_ovr = |sel_word[20:14];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Tag pipeline: {valid, id} moves forward one stage per cycle.
  // ---------------------------------------------------------------------
  assign tag_valid_next = (tag_valid_reg << 1) | LUT_LAT'(lut_en);
  assign tag_id_next    = (tag_id_reg << 2) | TID_W'(grant_id);
  assign retire_valid   = tag_valid_reg[LUT_LAT-1];
  assign retire_id      = tag_id_reg[TID_W-1 -: 2];

  // Advance the tag pipeline. Reset drops every pending lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_id_reg    <= tag_id_next;
    end
  end

  // A grant and a retire in the same cycle cancel out.
  assign inflight_next = inflight_reg + INF_W'(lut_en) - INF_W'(retire_valid);

  // Track the grant pointer and the number of lookups in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 2'd3;
      inflight_reg   <= '0;
    end else begin
      if (lut_en) begin
        last_grant_reg <= grant_id;
      end
      inflight_reg <= inflight_next;
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------
  assign push = retire_valid & ~rst;
  assign pop  = act_valid & act_ready;

  assign fifo_count_next = fifo_count_reg + CNT_W'(push) - CNT_W'(pop);

  // Write the completed lookup into the slot reserved at grant time.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= lut_dout;
      fifo_id_mem[wr_ptr_reg]   <= retire_id;
    end
  end

  // Update the FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      fifo_count_reg <= fifo_count_next;
    end
  end

  // The head entry is visible only while the FIFO holds data, so the
  // outputs read as zero after reset.
  assign act_valid = (fifo_count_reg != '0);
  assign act_data  = act_valid ? fifo_data_mem[rd_ptr_reg] : 8'd0;
  assign act_id    = act_valid ? fifo_id_mem[rd_ptr_reg]   : 2'd0;

  assign busy = (inflight_reg != '0) | (fifo_count_reg != '0);

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Self-checking bench for sigmoid_arbiter. A transaction-level model predicts
// every output in every cycle. The model keeps a list of pending lookups with
// due cycles, a result queue and the last-grant index.
module tb_sigmoid_arbiter;
  localparam int LUT_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [87:0] req_data;
  logic [3:0]  req_ready;
  logic        lut_en;
  logic [8:0]  lut_addr;
  logic        lut_sign;
  logic        lut_ovr;
  logic [7:0]  lut_dout;
  logic        act_valid;
  logic [7:0]  act_data;
  logic [1:0]  act_id;
  logic        act_ready;
  logic        busy;

  sigmoid_arbiter #(.LUT_LAT(LUT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .lut_en(lut_en), .lut_addr(lut_addr), .lut_sign(lut_sign), .lut_ovr(lut_ovr),
    .lut_dout(lut_dout),
    .act_valid(act_valid), .act_data(act_data), .act_id(act_id), .act_ready(act_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct { int id; int due; logic [7:0] data; } pend_t;
  typedef struct { int id; logic [7:0] data; } res_t;
  typedef struct {
    logic [1:0]  slot;
    logic        vld;
    logic [21:0] word;
    logic        exp_en;
    logic [8:0]  exp_addr;
    logic        exp_sign;
    logic        exp_ovr;
  } vec_t;

  pend_t      pendq[$];
  res_t       fifoq[$];
  int         last_grant;
  logic [7:0] lut_drive [int];
  vec_t       tbl [7];

  logic [3:0] obs_ready;
  logic       obs_en, obs_sign, obs_ovr, obs_av, obs_busy;
  logic [8:0] obs_addr;
  logic [7:0] obs_data;
  logic [1:0] obs_id;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endfunction

  // One clock cycle: drive the inputs, compare every output with the model,
  // then apply the clock edge to the model.
  task automatic step(input logic r, input logic [3:0] v, input logic [87:0] d, input logic ar);
    int         g;
    logic [21:0] w;
    int         sgn, ip, fr;
    logic       e_ovr, e_av;
    logic [3:0] e_ready;
    logic [7:0] val;
    pend_t      pe;
    res_t       re;
    rst       = r;
    req_valid = v;
    req_data  = d;
    act_ready = ar;
    if (lut_drive.exists(cyc)) begin
      lut_dout = lut_drive[cyc];
      lut_drive.delete(cyc);
    end else begin
      lut_dout = 8'($urandom);
    end
    #1;
    g = -1;
    if (!r && (pendq.size() + fifoq.size() < FIFO_DEPTH)) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && v[(last_grant + k) % 4]) g = (last_grant + k) % 4;
      end
    end
    e_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
    w       = (g >= 0) ? 22'(d >> (22 * g)) : 22'd0;
    sgn     = int'(w / 2097152);
    ip      = int'(w / 16384) % 128;
    fr      = int'(w / 32) % 512;
    e_ovr   = (sgn == 1) ? (ip != 127 || fr == 0) : (ip != 0);
    e_av    = (fifoq.size() != 0);
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("lut_en",    32'(lut_en),    32'(g >= 0));
    chk("lut_addr",  32'(lut_addr),  (g >= 0) ? 32'(fr) : 32'd0);
    chk("lut_sign",  32'(lut_sign),  (g >= 0) ? 32'(sgn) : 32'd0);
    chk("lut_ovr",   32'(lut_ovr),   (g >= 0) ? 32'(e_ovr) : 32'd0);
    chk("act_valid", 32'(act_valid), 32'(e_av));
    chk("act_data",  32'(act_data),  e_av ? 32'(fifoq[0].data) : 32'd0);
    chk("act_id",    32'(act_id),    e_av ? 32'(fifoq[0].id) : 32'd0);
    chk("busy",      32'(busy),      32'(pendq.size() != 0 || fifoq.size() != 0));
    obs_ready = req_ready; obs_en = lut_en; obs_addr = lut_addr; obs_sign = lut_sign;
    obs_ovr = lut_ovr; obs_av = act_valid; obs_data = act_data; obs_id = act_id; obs_busy = busy;
    @(posedge clk);
    if (r) begin
      pendq.delete();
      fifoq.delete();
      last_grant = 3;
    end else begin
      if (fifoq.size() != 0 && ar) begin
        $display("[TB] cyc=%0d pop id=%0d data=0x%02h", cyc, fifoq[0].id, fifoq[0].data);
        void'(fifoq.pop_front());
      end
      if (pendq.size() != 0 && pendq[0].due == cyc) begin
        re.id = pendq[0].id;
        re.data = pendq[0].data;
        fifoq.push_back(re);
        void'(pendq.pop_front());
      end
      if (g >= 0) begin
        val = 8'($urandom);
        pe.id = g;
        pe.due = cyc + LUT_LAT;
        pe.data = val;
        pendq.push_back(pe);
        lut_drive[cyc + LUT_LAT] = val;
        last_grant = g;
        $display("[TB] cyc=%0d grant id=%0d word=0x%06h", cyc, g, w);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [87:0] rnd_data();
    logic [87:0] d;
    logic [21:0] w;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       w = 22'($urandom);
        1:       w = {1'b0, 7'd0, 14'($urandom)};
        2:       w = {1'b1, 7'h7f, 14'($urandom)};
        default: w = {1'b1, 7'h7f, 9'd0, 5'($urandom)};
      endcase
      d[22*i +: 22] = w;
    end
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [87:0] d;
    tbl[0] = '{2'd0, 1'b1, 22'h000400, 1'b1, 9'h020, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 1'b1, 22'h004000, 1'b1, 9'h000, 1'b0, 1'b1};
    tbl[2] = '{2'd2, 1'b1, 22'h3FC000, 1'b1, 9'h000, 1'b1, 1'b1};
    tbl[3] = '{2'd3, 1'b1, 22'h3FC020, 1'b1, 9'h001, 1'b1, 1'b0};
    tbl[4] = '{2'd0, 1'b1, 22'h3F8020, 1'b1, 9'h001, 1'b1, 1'b1};
    tbl[5] = '{2'd1, 1'b1, 22'h001FE0, 1'b1, 9'h0FF, 1'b0, 1'b0};
    tbl[6] = '{2'd2, 1'b0, 22'h3FFFFF, 1'b0, 9'h000, 1'b0, 1'b0};

    rst = 1'b1; req_valid = '0; req_data = '0; act_ready = 1'b0; lut_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    last_grant = 3;

    // Reset state: requests are held off while rst is high.
    step(1'b1, 4'hF, rnd_data(), 1'b1);
    chk("rst_ready", 32'(obs_ready), 32'd0);
    chk("rst_act_valid", 32'(obs_av), 32'd0);
    chk("rst_busy", 32'(obs_busy), 32'd0);
    chk("rst_act_data", 32'(obs_data), 32'd0);
    chk("rst_act_id", 32'(obs_id), 32'd0);

    // A single positive request; its result appears on the third edge.
    step(1'b0, 4'b0001, {66'd0, 22'h000400}, 1'b0);
    chk("lat_en", 32'(obs_en), 32'd1);
    chk("lat_addr", 32'(obs_addr), 32'h020);
    chk("lat_sign", 32'(obs_sign), 32'd0);
    chk("lat_ovr", 32'(obs_ovr), 32'd0);
    step(1'b0, 4'd0, 88'd0, 1'b0);
    chk("lat_av_e1", 32'(obs_av), 32'd0);
    step(1'b0, 4'd0, 88'd0, 1'b0);
    chk("lat_av_e2", 32'(obs_av), 32'd0);
    step(1'b0, 4'd0, 88'd0, 1'b0);
    chk("lat_av_e3", 32'(obs_av), 32'd1);
    chk("lat_id", 32'(obs_id), 32'd0);

    // Field-mapping vectors.
    for (int i = 0; i < 7; i++) begin
      d = 88'(tbl[i].word) << (22 * tbl[i].slot);
      step(1'b0, tbl[i].vld ? 4'(1 << tbl[i].slot) : 4'd0, d, 1'b1);
      chk("tbl_ready", 32'(obs_ready), tbl[i].vld ? 32'(1 << tbl[i].slot) : 32'd0);
      chk("tbl_en", 32'(obs_en), 32'(tbl[i].exp_en));
      chk("tbl_addr", 32'(obs_addr), 32'(tbl[i].exp_addr));
      chk("tbl_sign", 32'(obs_sign), 32'(tbl[i].exp_sign));
      chk("tbl_ovr", 32'(obs_ovr), 32'(tbl[i].exp_ovr));
    end
    repeat (10) step(1'b0, 4'd0, 88'd0, 1'b1);

    // Fairness: all requesters valid, one result per cycle.
    step(1'b1, 4'd0, 88'd0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 4'hF, rnd_data(), 1'b1);
      if (k < 6) chk("fair_grant", 32'(obs_ready), 32'(1 << (k % 4)));
      if (k >= 3) begin
        chk("fair_av", 32'(obs_av), 32'd1);
        chk("fair_id", 32'(obs_id), 32'((k - 3) % 4));
      end
    end

    // Backpressure: credits run out after FIFO_DEPTH grants.
    step(1'b1, 4'd0, 88'd0, 1'b0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'hF, rnd_data(), 1'b0);
      if (obs_ready != 4'd0) n++;
    end
    chk("bp_grants", 32'(n), 32'(FIFO_DEPTH));
    step(1'b0, 4'hF, rnd_data(), 1'b0);
    chk("bp_blocked", 32'(obs_ready), 32'd0);
    step(1'b0, 4'hF, rnd_data(), 1'b1);
    chk("bp_pop_cycle_ready", 32'(obs_ready), 32'd0);
    chk("bp_pop_av", 32'(obs_av), 32'd1);
    step(1'b0, 4'hF, rnd_data(), 1'b0);
    chk("bp_one_grant", 32'(obs_ready), 32'b0001);
    step(1'b0, 4'hF, rnd_data(), 1'b0);
    chk("bp_blocked2", 32'(obs_ready), 32'd0);

    // Reset mid-flight: two lookups pending and one buffered result.
    step(1'b1, 4'd0, 88'd0, 1'b0);
    step(1'b0, 4'b0001, rnd_data(), 1'b0);
    step(1'b0, 4'b0010, rnd_data(), 1'b0);
    step(1'b0, 4'b0100, rnd_data(), 1'b0);
    step(1'b1, 4'd0, rnd_data(), 1'b0);
    chk("mf_pre_av", 32'(obs_av), 32'd1);
    chk("mf_pre_busy", 32'(obs_busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'd0, rnd_data(), 1'b0);
      chk("mf_av", 32'(obs_av), 32'd0);
      chk("mf_busy", 32'(obs_busy), 32'd0);
    end
    step(1'b0, 4'hF, rnd_data(), 1'b0);
    chk("mf_next_grant", 32'(obs_ready), 32'b0001);

    // Random traffic with occasional reset.
    step(1'b1, 4'd0, 88'd0, 1'b0);
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 99) == 0), 4'($urandom), rnd_data(),
           ($urandom_range(0, 9) < 7));
    end
    repeat (10) step(1'b0, 4'd0, 88'd0, 1'b1);
    chk("end_busy", 32'(obs_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
